// File: rtl/dcache_store_port.sv
// ---------------------------------------------------------------------------
// dcache_store_port
//   L1 D$ store-side responder. Takes one committed store at a time from the
//   store buffer, builds byte-lane data/strobes, does a tag lookup, writes the
//   data array on a hit (write-through, no-write-allocate) and always forwards
//   the write to the memory bus.
//
//   Ports
//     clk_i, rst_i              clock, async active-high reset
//     req_valid_i/req_ready_o   store request handshake (ready == idle)
//     req_addr_i/data_i/op_i    byte address, right-aligned data, LSU op
//     lookup_req_o/addr_o       one-cycle tag lookup strobe + address
//     lookup_hit_i              hit result, valid the cycle after the strobe
//     data_we_o/idx_o/wdata_o/wstrb_o   data-array write port
//     mem_req_*                 memory write request (valid/ready)
//     mem_resp_valid_i          memory write acknowledge
//     err_o                     one-cycle pulse for a dropped illegal request
//     store_cnt_o, hit_cnt_o    saturating completed-store / hit counters
// ---------------------------------------------------------------------------

package decode_pkg;
  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LBU  = 4'd2,
    LSU_LH   = 4'd3,
    LSU_LHU  = 4'd4,
    LSU_LW   = 4'd5,
    LSU_SB   = 4'd6,
    LSU_SH   = 4'd7,
    LSU_SW   = 4'd8
  } lsu_op_e;
endpackage

// ---------------------------------------------------------------------------
// dcache_store_lane
//   One byte lane of the store data path. Picks the byte this lane carries
//   for each store size and decides whether the lane is strobed.
//     op       LSU op
//     a        address low bits
//     sb_byte  data[7:0]                    (SB replicates the low byte)
//     sh_byte  data[8*(LANE%2)+:8]          (SH replicates the low half)
//     sw_byte  data[8*LANE+:8]              (SW passes the word through)
//     lane_data / lane_strb   lane outputs
// ---------------------------------------------------------------------------
module dcache_store_lane
  import decode_pkg::*;
#(
  parameter int LANE = 0
) (
  input  lsu_op_e    op,
  input  logic [1:0] a,
  input  logic [7:0] sb_byte,
  input  logic [7:0] sh_byte,
  input  logic [7:0] sw_byte,
  output logic [7:0] lane_data,
  output logic       lane_strb
);
  localparam logic [1:0] LIDX = 2'(LANE);

  always_comb begin
    lane_data = sw_byte;
    lane_strb = 1'b0;
    case (op)
      LSU_SB: begin
        lane_data = sb_byte;
        lane_strb = (a == LIDX);
      end
      LSU_SH: begin
        lane_data = sh_byte;
        lane_strb = (a[1] == LIDX[1]);
      end
      LSU_SW: begin
        lane_data = sw_byte;
        lane_strb = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// ---------------------------------------------------------------------------
// dcache_store_port top
// ---------------------------------------------------------------------------
module dcache_store_port
  import decode_pkg::*;
#(
  parameter int PLEN  = 32,
  parameter int XLEN  = 32,   // only 32 is supported (4 byte lanes)
  parameter int IDX_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // store buffer side
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [PLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_data_i,
  input  lsu_op_e           req_op_i,
  // tag lookup
  output logic              lookup_req_o,
  output logic [PLEN-1:0]   lookup_addr_o,
  input  logic              lookup_hit_i,
  // data array
  output logic              data_we_o,
  output logic [IDX_W-1:0]  data_idx_o,
  output logic [XLEN-1:0]   data_wdata_o,
  output logic [3:0]        data_wstrb_o,
  // memory bus
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [PLEN-1:0]   mem_req_addr_o,
  output logic [XLEN-1:0]   mem_req_data_o,
  output logic [3:0]        mem_req_strb_o,
  input  logic              mem_resp_valid_i,
  // status
  output logic              err_o,
  output logic [31:0]       store_cnt_o,
  output logic [31:0]       hit_cnt_o
);
  localparam int NUM_LANES = XLEN / 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_UPDATE   = 3'd2;
  localparam logic [2:0] S_MEM_REQ  = 3'd3;
  localparam logic [2:0] S_MEM_WAIT = 3'd4;

  typedef struct packed {
    logic [PLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata;
    logic [NUM_LANES-1:0] wstrb;
  } st_req_t;

  logic [2:0] state_q, state_d;
  st_req_t    req_q;
  st_req_t    req_d;
  logic       err_q;
  logic [31:0] store_cnt_q, hit_cnt_q;

  // ---- per-lane data/strobe generation ----
  logic [1:0]                  a;
  logic [NUM_LANES-1:0][7:0]   lane_data;
  logic [NUM_LANES-1:0]        lane_strb;

  assign a = req_addr_i[1:0];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dcache_store_lane #(.LANE(l)) u_lane (
      .op        (req_op_i),
      .a         (a),
      .sb_byte   (req_data_i[7:0]),
      .sh_byte   (req_data_i[8*(l%2) +: 8]),
      .sw_byte   (req_data_i[8*l +: 8]),
      .lane_data (lane_data[l]),
      .lane_strb (lane_strb[l])
    );
  end

  logic legal;
  always_comb begin
    legal = 1'b0;
    case (req_op_i)
      LSU_SB:  legal = 1'b1;
      LSU_SH:  legal = ~a[0];
      LSU_SW:  legal = (a == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  logic accept;
  assign accept = (state_q == S_IDLE) && req_valid_i;

  assign req_d = '{addr: req_addr_i, wdata: lane_data, wstrb: lane_strb};

  // ---- FSM ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_valid_i && legal) state_d = S_LOOKUP;
      S_LOOKUP:   state_d = S_UPDATE;
      S_UPDATE:   state_d = S_MEM_REQ;
      S_MEM_REQ:  if (mem_req_ready_i) state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (mem_resp_valid_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      err_q       <= 1'b0;
      store_cnt_q <= '0;
      hit_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !legal;
      // Latched even for an illegal op; harmless since nothing downstream
      // is strobed and the next accept overwrites it.
      if (accept) req_q <= req_d;
      if (state_q == S_UPDATE && lookup_hit_i && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == S_MEM_WAIT && mem_resp_valid_i && store_cnt_q != '1)
        store_cnt_q <= store_cnt_q + 32'd1;
    end
  end

  // ---- outputs: strobes decode straight from state so reset kills them at once ----
  assign req_ready_o     = (state_q == S_IDLE);
  assign lookup_req_o    = (state_q == S_LOOKUP);
  assign lookup_addr_o   = req_q.addr;
  assign data_we_o       = (state_q == S_UPDATE) && lookup_hit_i;
  assign data_idx_o      = req_q.addr[IDX_W+1:2];
  assign data_wdata_o    = req_q.wdata;
  assign data_wstrb_o    = req_q.wstrb;
  assign mem_req_valid_o = (state_q == S_MEM_REQ);
  assign mem_req_addr_o  = {req_q.addr[PLEN-1:2], 2'b00};
  assign mem_req_data_o  = req_q.wdata;
  assign mem_req_strb_o  = req_q.wstrb;
  assign err_o           = err_q;
  assign store_cnt_o     = store_cnt_q;
  assign hit_cnt_o       = hit_cnt_q;

endmodule
